// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT block: sequencer states, default
// geometry, and the packed complex word layout used by the butterfly wrappers.
package fft_pkg;

    localparam int LOG2N_DEF    = 3;
    localparam int PIPE_LAT_DEF = 6;

    // Packed complex word: real in the upper half, imaginary in the lower half.
    localparam int CPX_W     = 32;
    localparam int CPX_RE_HI = 31;
    localparam int CPX_RE_LO = 16;
    localparam int CPX_IM_HI = 15;
    localparam int CPX_IM_LO = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: carries {valid, addrA, addrB} from the issue point
// to the write-back point, DEPTH cycles later.
module fft_wb_delay #(
    parameter int DEPTH = 6,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [AW-1:0] in_a,
    input  logic [AW-1:0] in_b,
    output logic          out_vld,
    output logic [AW-1:0] out_a,
    output logic [AW-1:0] out_b
);

    logic [DEPTH-1:0]         vld_pipe;
    logic [DEPTH-1:0][AW-1:0] a_pipe;
    logic [DEPTH-1:0][AW-1:0] b_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            a_pipe[0]   <= in_a;
            b_pipe[0]   <= in_b;
            for (int i = 1; i < DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
                b_pipe[i]   <= b_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[DEPTH-1];
    assign out_a   = a_pipe[DEPTH-1];
    assign out_b   = b_pipe[DEPTH-1];

endmodule

// File: rtl/fft_r2_sequencer.sv
// In-place radix-2 DIT FFT scheduler: one butterfly issue per cycle, with the
// butterfly pipeline drained between stages so no stage reads stale data.
module fft_r2_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N    = LOG2N_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Hold,
    output logic             Busy,
    output logic             Done,
    output logic [LOG2N-1:0] Stage,
    output logic             RdEn,
    output logic [LOG2N-1:0] RdAddrA,
    output logic [LOG2N-1:0] RdAddrB,
    output logic [LOG2N-2:0] TwAddr,
    output logic             WrEn,
    output logic [LOG2N-1:0] WrAddrA,
    output logic [LOG2N-1:0] WrAddrB
);

    localparam int KW = LOG2N - 1;
    localparam int CW = $clog2(PIPE_LAT + 1);

    seq_state_t       state, state_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic [CW-1:0]    drain_cnt, drain_cnt_nxt;
    logic [LOG2N-1:0] stage, stage_nxt;
    logic             rd_en, rd_en_nxt, busy, busy_nxt, done, done_nxt;
    logic [LOG2N-1:0] rd_a, rd_a_nxt, rd_b, rd_b_nxt;
    logic [KW-1:0]    tw, tw_nxt;

    logic [LOG2N-1:0] span, base, addr_a, addr_b;
    logic [KW-1:0]    pos_mask, pos_k, tw_c;

    always_comb begin
        // Butterfly k of stage s: A = grp*2*span + pos, B = A + span.
        span     = LOG2N'(1) << stage;
        pos_mask = ~({KW{1'b1}} << stage);
        pos_k    = k & pos_mask;
        base     = ({1'b0, k} >> stage) << (stage + LOG2N'(1));
        addr_a   = base | {1'b0, pos_k};
        addr_b   = addr_a | span;
        tw_c     = pos_k << (LOG2N'(KW) - stage);

        state_nxt     = state;
        k_nxt         = k;
        drain_cnt_nxt = drain_cnt;
        stage_nxt     = stage;
        rd_en_nxt     = 1'b0;
        rd_a_nxt      = rd_a;
        rd_b_nxt      = rd_b;
        tw_nxt        = tw;
        busy_nxt      = busy;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                k_nxt         = '0;
                drain_cnt_nxt = '0;
                stage_nxt     = '0;
                if (Start) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!Hold) begin
                    rd_en_nxt = 1'b1;
                    rd_a_nxt  = addr_a;
                    rd_b_nxt  = addr_b;
                    tw_nxt    = tw_c;
                    busy_nxt  = 1'b1;
                    k_nxt     = k + KW'(1);
                    if (k == {KW{1'b1}}) begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = '0;
                    end
                end
            end
            DRAIN: begin
                // The last issue of the stage writes back PIPE_LAT cycles later.
                if (drain_cnt == CW'(PIPE_LAT - 1)) begin
                    drain_cnt_nxt = '0;
                    if (stage == LOG2N'(LOG2N - 1)) begin
                        state_nxt = FINISH;
                    end else begin
                        stage_nxt = stage + LOG2N'(1);
                        state_nxt = ISSUE;
                    end
                end else begin
                    drain_cnt_nxt = drain_cnt + CW'(1);
                end
            end
            FINISH: begin
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                stage_nxt = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            k         <= '0;
            drain_cnt <= '0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_a      <= '0;
            rd_b      <= '0;
            tw        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            drain_cnt <= drain_cnt_nxt;
            stage     <= stage_nxt;
            rd_en     <= rd_en_nxt;
            rd_a      <= rd_a_nxt;
            rd_b      <= rd_b_nxt;
            tw        <= tw_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    fft_wb_delay #(
        .DEPTH (PIPE_LAT),
        .AW    (LOG2N)
    ) u_wb_delay (
        .clk     (Clk),
        .rst     (Rst),
        .in_vld  (rd_en),
        .in_a    (rd_a),
        .in_b    (rd_b),
        .out_vld (WrEn),
        .out_a   (WrAddrA),
        .out_b   (WrAddrB)
    );

    assign Busy    = busy;
    assign Done    = done;
    assign Stage   = stage;
    assign RdEn    = rd_en;
    assign RdAddrA = rd_a;
    assign RdAddrB = rd_b;
    assign TwAddr  = tw;

endmodule

// File: tb/tb_fft_r2_sequencer.sv
// Bench for fft_r2_sequencer: N=8/PIPE_LAT=6 and N=16/PIPE_LAT=1 instances,
// outputs compared cycle by cycle against an event-schedule model.
module tb_fft_r2_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rden;
        logic [3:0] stg;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] tw;
        logic       wren;
        logic [3:0] wa;
        logic [3:0] wb;
    } ev_t;

    localparam int MAXC = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b0, start0 = 1'b0, hold0 = 1'b0;
    logic       busy0, done0, rd0, wr0;
    logic [2:0] stg0, ra0, rb0, wa0, wb0;
    logic [1:0] tw0;

    logic       rst1 = 1'b0, start1 = 1'b0, hold1 = 1'b0;
    logic       busy1, done1, rd1, wr1;
    logic [3:0] stg1, ra1, rb1, wa1, wb1;
    logic [2:0] tw1;

    fft_r2_sequencer #(.LOG2N(3), .PIPE_LAT(6)) u_dut8 (
        .Clk(clk), .Rst(rst0), .Start(start0), .Hold(hold0),
        .Busy(busy0), .Done(done0), .Stage(stg0), .RdEn(rd0),
        .RdAddrA(ra0), .RdAddrB(rb0), .TwAddr(tw0),
        .WrEn(wr0), .WrAddrA(wa0), .WrAddrB(wb0)
    );

    fft_r2_sequencer #(.LOG2N(4), .PIPE_LAT(1)) u_dut16 (
        .Clk(clk), .Rst(rst1), .Start(start1), .Hold(hold1),
        .Busy(busy1), .Done(done1), .Stage(stg1), .RdEn(rd1),
        .RdAddrA(ra1), .RdAddrB(rb1), .TwAddr(tw1),
        .WrEn(wr1), .WrAddrA(wa1), .WrAddrB(wb1)
    );

    // Addresses only matter while their strobe is up; Stage is left free while
    // the pipeline drains between stages.
    ev_t ev0, ev1;
    always_comb begin
        ev0      = '0;
        ev0.busy = busy0;
        ev0.done = done0;
        ev0.rden = rd0;
        ev0.stg  = (busy0 && !rd0) ? 4'd0 : {1'b0, stg0};
        ev0.ra   = rd0 ? {1'b0, ra0} : 4'd0;
        ev0.rb   = rd0 ? {1'b0, rb0} : 4'd0;
        ev0.tw   = rd0 ? {1'b0, tw0} : 3'd0;
        ev0.wren = wr0;
        ev0.wa   = wr0 ? {1'b0, wa0} : 4'd0;
        ev0.wb   = wr0 ? {1'b0, wb0} : 4'd0;
    end
    always_comb begin
        ev1      = '0;
        ev1.busy = busy1;
        ev1.done = done1;
        ev1.rden = rd1;
        ev1.stg  = (busy1 && !rd1) ? 4'd0 : stg1;
        ev1.ra   = rd1 ? ra1 : 4'd0;
        ev1.rb   = rd1 ? rb1 : 4'd0;
        ev1.tw   = rd1 ? tw1 : 3'd0;
        ev1.wren = wr1;
        ev1.wa   = wr1 ? wa1 : 4'd0;
        ev1.wb   = wr1 ? wb1 : 4'd0;
    end

    int   checks = 0;
    int   errors = 0;
    logic start_pat [MAXC];
    logic hold_pat  [MAXC];
    logic rst_pat   [MAXC];
    ev_t  exp_ev    [MAXC];
    ev_t  obs_ev    [MAXC];

    task automatic clr_all();
        for (int c = 0; c < MAXC; c++) begin
            start_pat[c] = 1'b0;
            hold_pat[c]  = 1'b0;
            rst_pat[c]   = 1'b0;
            exp_ev[c]    = '0;
            obs_ev[c]    = '0;
        end
    endtask

    // Schedule model: issues fill free (Hold=0) cycles in butterfly order; each
    // stage's writes land lat cycles later and the next stage starts right after.
    task automatic model_xfer(input int sel, input int t0, output int tdone);
        int lg, n2, lat, c, first, lastwr, span, a;
        lg     = sel ? 4 : 3;
        n2     = 1 << (lg - 1);
        lat    = sel ? 1 : 6;
        c      = t0 + 1;
        first  = -1;
        lastwr = 0;
        for (int s = 0; s < lg; s++) begin
            span = 1 << s;
            for (int k = 0; k < n2; k++) begin
                while (c < 250 && hold_pat[c]) c++;
                a = (k / span) * 2 * span + (k % span);
                exp_ev[c].rden = 1'b1;
                exp_ev[c].stg  = 4'(s);
                exp_ev[c].ra   = 4'(a);
                exp_ev[c].rb   = 4'(a + span);
                exp_ev[c].tw   = 3'((k % span) * (n2 / span));
                exp_ev[c+lat].wren = 1'b1;
                exp_ev[c+lat].wa   = 4'(a);
                exp_ev[c+lat].wb   = 4'(a + span);
                if (first < 0) first = c;
                c++;
            end
            lastwr = c - 1 + lat;
            c = lastwr + 1;
        end
        for (int cc = first; cc <= lastwr; cc++) exp_ev[cc].busy = 1'b1;
        tdone = lastwr + 1;
        exp_ev[tdone].done = 1'b1;
    endtask

    task automatic drive(input int sel, input int c);
        if (sel != 0) begin
            start1 = start_pat[c]; hold1 = hold_pat[c]; rst1 = rst_pat[c];
        end else begin
            start0 = start_pat[c]; hold0 = hold_pat[c]; rst0 = rst_pat[c];
        end
    endtask

    // Cycle c is the interval after rising edge c; pattern[c] is sampled at edge c.
    task automatic capture(input int sel, input int ncyc);
        drive(sel, 0);
        for (int c = 0; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            obs_ev[c] = (sel != 0) ? ev1 : ev0;
            drive(sel, c + 1);
        end
        start0 = 1'b0; hold0 = 1'b0; rst0 = 1'b0;
        start1 = 1'b0; hold1 = 1'b0; rst1 = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy0, done0, rd0, wr0, stg0, ra0, rb0, tw0, wa0, wb0} !== '0) begin
            errors++;
            $display("FAIL reset8 got=%h exp=0", {busy0, done0, rd0, wr0, stg0, ra0, rb0, tw0, wa0, wb0});
        end
        checks++;
        if ({busy1, done1, rd1, wr1, stg1, ra1, rb1, tw1, wa1, wb1} !== '0) begin
            errors++;
            $display("FAIL reset16 got=%h exp=0", {busy1, done1, rd1, wr1, stg1, ra1, rb1, tw1, wa1, wb1});
        end
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int td;
        clr_all();
        start_pat[0] = 1'b1;
        model_xfer(0, 0, td);
        capture(0, td + 4);
        for (int c = 0; c <= td + 4; c++) begin
            checks++;
            if (obs_ev[c] !== exp_ev[c]) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", c, obs_ev[c], exp_ev[c]);
            end
        end
        checks++;
        if (obs_ev[31].done !== 1'b1 || obs_ev[30].busy !== 1'b1 || obs_ev[31].busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got done31=%b busy30=%b busy31=%b exp 1 1 0",
                     obs_ev[31].done, obs_ev[30].busy, obs_ev[31].busy);
        end
    endtask

    task automatic test_hold_fixed();
        int td;
        clr_all();
        start_pat[0] = 1'b1;
        hold_pat[2]  = 1'b1;
        hold_pat[3]  = 1'b1;
        model_xfer(0, 0, td);
        capture(0, td + 4);
        for (int c = 0; c <= td + 4; c++) begin
            checks++;
            if (obs_ev[c] !== exp_ev[c]) begin
                errors++;
                $display("FAIL hold_fixed cyc=%0d got=%h exp=%h", c, obs_ev[c], exp_ev[c]);
            end
        end
        checks++;
        if (obs_ev[13].rden !== 1'b1 || obs_ev[12].wren !== 1'b1 || obs_ev[2].rden !== 1'b0) begin
            errors++;
            $display("FAIL hold_fixed_pts got rd13=%b wr12=%b rd2=%b exp 1 1 0",
                     obs_ev[13].rden, obs_ev[12].wren, obs_ev[2].rden);
        end
    endtask

    task automatic test_start_ignored();
        int td;
        clr_all();
        start_pat[0]  = 1'b1;
        start_pat[5]  = 1'b1;
        start_pat[15] = 1'b1;
        model_xfer(0, 0, td);
        capture(0, td + 4);
        for (int c = 0; c <= td + 4; c++) begin
            checks++;
            if (obs_ev[c] !== exp_ev[c]) begin
                errors++;
                $display("FAIL start_ignored cyc=%0d got=%h exp=%h", c, obs_ev[c], exp_ev[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int td;
        clr_all();
        start_pat[0]  = 1'b1;
        rst_pat[12]   = 1'b1;
        start_pat[16] = 1'b1;
        model_xfer(0, 0, td);
        for (int c = 12; c < MAXC; c++) exp_ev[c] = '0;
        model_xfer(0, 16, td);
        capture(0, td + 4);
        for (int c = 0; c <= td + 4; c++) begin
            checks++;
            if (obs_ev[c] !== exp_ev[c]) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, obs_ev[c], exp_ev[c]);
            end
        end
    endtask

    task automatic test_log2n4();
        int td, nbusy;
        clr_all();
        start_pat[0] = 1'b1;
        model_xfer(1, 0, td);
        capture(1, td + 4);
        nbusy = 0;
        for (int c = 0; c <= td + 4; c++) begin
            if (obs_ev[c].busy === 1'b1) nbusy++;
            checks++;
            if (obs_ev[c] !== exp_ev[c]) begin
                errors++;
                $display("FAIL log2n4 cyc=%0d got=%h exp=%h", c, obs_ev[c], exp_ev[c]);
            end
        end
        checks++;
        if (nbusy != 36 || obs_ev[37].done !== 1'b1) begin
            errors++;
            $display("FAIL log2n4_len got busy=%0d done37=%b exp 36 1", nbusy, obs_ev[37].done);
        end
    endtask

    task automatic test_back_to_back();
        int td, td2;
        clr_all();
        start_pat[0] = 1'b1;
        model_xfer(0, 0, td);
        start_pat[td+2] = 1'b1;
        model_xfer(0, td + 2, td2);
        capture(0, td2 + 3);
        for (int c = 0; c <= td2 + 3; c++) begin
            checks++;
            if (obs_ev[c] !== exp_ev[c]) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs_ev[c], exp_ev[c]);
            end
        end
    endtask

    task automatic test_hold_random();
        int td, sel;
        for (int r = 0; r < 6; r++) begin
            sel = r % 2;
            clr_all();
            start_pat[0] = 1'b1;
            for (int c = 1; c < 200; c++) hold_pat[c] = ($urandom_range(0, 2) == 0);
            model_xfer(sel, 0, td);
            capture(sel, td + 3);
            for (int c = 0; c <= td + 3; c++) begin
                checks++;
                if (obs_ev[c] !== exp_ev[c]) begin
                    errors++;
                    $display("FAIL hold_random run=%0d cyc=%0d got=%h exp=%h", r, c, obs_ev[c], exp_ev[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_fixed();
        test_start_ignored();
        test_reset_mid();
        test_log2n4();
        test_back_to_back();
        test_hold_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
